// File: rtl/glyph_scan_ctrl_pkg.sv
// Shared definitions for the glyph scan controller: character codes, glyph geometry
// and the raster position handed from the tracker to the fetch pipe.
package glyph_scan_ctrl_pkg;

    localparam logic [3:0] CH_0     = 4'd0;
    localparam logic [3:0] CH_1     = 4'd1;
    localparam logic [3:0] CH_2     = 4'd2;
    localparam logic [3:0] CH_3     = 4'd3;
    localparam logic [3:0] CH_4     = 4'd4;
    localparam logic [3:0] CH_5     = 4'd5;
    localparam logic [3:0] CH_6     = 4'd6;
    localparam logic [3:0] CH_7     = 4'd7;
    localparam logic [3:0] CH_8     = 4'd8;
    localparam logic [3:0] CH_9     = 4'd9;
    localparam logic [3:0] CH_ADD   = 4'd10;
    localparam logic [3:0] CH_SUB   = 4'd11;
    localparam logic [3:0] CH_MUL   = 4'd12;
    localparam logic [3:0] CH_DIV   = 4'd13;
    localparam logic [3:0] CH_EQ    = 4'd14;
    localparam logic [3:0] CH_BLANK = 4'd15;

    localparam int unsigned GLYPH_W = 5;
    localparam int unsigned GLYPH_H = 5;

    typedef struct packed {
        logic       h_act;
        logic [3:0] char_idx;
        logic [2:0] dot_col;
        logic [2:0] dot_row;
    } scan_pos_t;

endpackage

// File: rtl/glyph_scan_ctrl_raster.sv
// Incremental raster tracker: derives character, dot column and dot row of the
// current pixel from pixel_x/pixel_y without any multiply or divide.
module glyph_scan_ctrl_raster
    import glyph_scan_ctrl_pkg::*;
#(
    parameter int unsigned ORIGIN_X  = 64,
    parameter int unsigned ORIGIN_Y  = 200,
    parameter int unsigned SCALE     = 8,
    parameter int unsigned NUM_CHARS = 8,
    parameter int unsigned CELL_DOTS = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_tick_i,
    input  logic [9:0] pixel_x_i,
    input  logic [9:0] pixel_y_i,
    output scan_pos_t  pos_o
);

    localparam logic [9:0] X0        = 10'(ORIGIN_X);
    localparam logic [9:0] Y0        = 10'(ORIGIN_Y);
    localparam logic [3:0] SUB_LAST  = 4'(SCALE - 1);
    localparam logic [2:0] COL_LAST  = 3'(CELL_DOTS - 1);
    localparam logic [2:0] ROW_LAST  = 3'(GLYPH_H - 1);
    localparam logic [3:0] CHAR_LAST = 4'(NUM_CHARS - 1);

    logic [3:0] sub_y_q, sub_y_d, sub_x_q, sub_x_d;
    logic [2:0] dot_row_q, dot_row_d, dot_col_q, dot_col_d;
    logic [3:0] char_idx_q, char_idx_d;
    logic       v_act_q, v_act_d, h_act_q, h_act_d;

    // The _d values describe the pixel presented this tick, so the fetch stage
    // samples them directly to keep the total latency at two ticks.
    always_comb begin
        sub_y_d   = sub_y_q;
        dot_row_d = dot_row_q;
        v_act_d   = v_act_q;
        if (pixel_x_i == '0) begin
            if (pixel_y_i == Y0) begin
                sub_y_d   = '0;
                dot_row_d = '0;
                v_act_d   = 1'b1;
            end else if (v_act_q) begin
                if (sub_y_q == SUB_LAST) begin
                    sub_y_d = '0;
                    if (dot_row_q == ROW_LAST) begin
                        dot_row_d = '0;
                        v_act_d   = 1'b0;
                    end else begin
                        dot_row_d = dot_row_q + 3'd1;
                    end
                end else begin
                    sub_y_d = sub_y_q + 4'd1;
                end
            end
        end
    end

    always_comb begin
        sub_x_d    = sub_x_q;
        dot_col_d  = dot_col_q;
        char_idx_d = char_idx_q;
        h_act_d    = h_act_q;
        if (pixel_x_i == X0 && v_act_q) begin
            sub_x_d    = '0;
            dot_col_d  = '0;
            char_idx_d = '0;
            h_act_d    = 1'b1;
        end else if (pixel_x_i == '0) begin
            h_act_d = 1'b0;
        end else if (h_act_q) begin
            if (sub_x_q == SUB_LAST) begin
                sub_x_d = '0;
                if (dot_col_q == COL_LAST) begin
                    dot_col_d = '0;
                    if (char_idx_q == CHAR_LAST) begin
                        char_idx_d = '0;
                        h_act_d    = 1'b0;
                    end else begin
                        char_idx_d = char_idx_q + 4'd1;
                    end
                end else begin
                    dot_col_d = dot_col_q + 3'd1;
                end
            end else begin
                sub_x_d = sub_x_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sub_y_q    <= '0;
            dot_row_q  <= '0;
            v_act_q    <= 1'b0;
            sub_x_q    <= '0;
            dot_col_q  <= '0;
            char_idx_q <= '0;
            h_act_q    <= 1'b0;
        end else if (pix_tick_i) begin
            sub_y_q    <= sub_y_d;
            dot_row_q  <= dot_row_d;
            v_act_q    <= v_act_d;
            sub_x_q    <= sub_x_d;
            dot_col_q  <= dot_col_d;
            char_idx_q <= char_idx_d;
            h_act_q    <= h_act_d;
        end
    end

    assign pos_o = {h_act_d, char_idx_d, dot_col_d, dot_row_d};

endmodule

// File: rtl/glyph_scan_ctrl.sv
// Glyph scan controller: display string register file, raster tracking and the
// two-stage glyph fetch / pixel serialise pipe feeding the VGA output.
module glyph_scan_ctrl
    import glyph_scan_ctrl_pkg::*;
#(
    parameter int unsigned ORIGIN_X  = 64,
    parameter int unsigned ORIGIN_Y  = 200,
    parameter int unsigned SCALE     = 8,
    parameter int unsigned NUM_CHARS = 8,
    parameter int unsigned CELL_DOTS = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_tick,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       video_on,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_char,
    output logic [3:0] glyph_sel,
    output logic [2:0] glyph_row,
    input  logic [4:0] glyph_code,
    output logic       pixel_on
);

    scan_pos_t  pos;
    logic [3:0] slot_q [16];

    logic [3:0] s0_sel_q, s0_sel_d;
    logic [2:0] s0_row_q, s0_row_d;
    logic [2:0] s0_col_q, s0_col_d;
    logic       s0_act_q, s0_act_d;
    logic       pix_q, pix_d;
    logic [4:0] code_shift;

    glyph_scan_ctrl_raster #(
        .ORIGIN_X  (ORIGIN_X),
        .ORIGIN_Y  (ORIGIN_Y),
        .SCALE     (SCALE),
        .NUM_CHARS (NUM_CHARS),
        .CELL_DOTS (CELL_DOTS)
    ) u_raster (
        .clk        (clk),
        .rst        (rst),
        .pix_tick_i (pix_tick),
        .pixel_x_i  (pixel_x),
        .pixel_y_i  (pixel_y),
        .pos_o      (pos)
    );

    // Sized to the full 4-bit address space; slots at or above NUM_CHARS are never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 16; i++) slot_q[i] <= CH_BLANK;
        end else if (wr_en && (32'(wr_addr) < NUM_CHARS)) begin
            slot_q[wr_addr] <= wr_char;
        end
    end

    always_comb begin
        s0_sel_d   = pos.h_act ? slot_q[pos.char_idx] : CH_BLANK;
        s0_row_d   = pos.dot_row;
        s0_col_d   = pos.dot_col;
        s0_act_d   = pos.h_act & video_on;
        code_shift = glyph_code << s0_col_q;
        pix_d      = s0_act_q & (s0_col_q < 3'(GLYPH_W)) & code_shift[4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_sel_q <= CH_BLANK;
            s0_row_q <= '0;
            s0_col_q <= '0;
            s0_act_q <= 1'b0;
            pix_q    <= 1'b0;
        end else if (pix_tick) begin
            s0_sel_q <= s0_sel_d;
            s0_row_q <= s0_row_d;
            s0_col_q <= s0_col_d;
            s0_act_q <= s0_act_d;
            pix_q    <= pix_d;
        end
    end

    assign glyph_sel = s0_sel_q;
    assign glyph_row = s0_row_q;
    assign pixel_on  = pix_q;

endmodule

// File: tb/tb_glyph_scan_ctrl.sv
// Self-checking bench for glyph_scan_ctrl: drives a shortened raster, models the
// glyph ROM mux, and scores every pixel against a geometric reference.
module tb_glyph_scan_ctrl;

    localparam int OX     = 64;
    localparam int OY     = 200;
    localparam int SC     = 8;
    localparam int NC     = 8;
    localparam int CD     = 6;
    localparam int LINE_W = 456;

    logic       clk = 1'b0;
    logic       rst, pix_tick, video_on, wr_en, pixel_on;
    logic [9:0] pixel_x, pixel_y;
    logic [3:0] wr_addr, wr_char, glyph_sel;
    logic [2:0] glyph_row;
    logic [4:0] glyph_code;

    always #5 clk = ~clk;

    glyph_scan_ctrl #(
        .ORIGIN_X  (OX),
        .ORIGIN_Y  (OY),
        .SCALE     (SC),
        .NUM_CHARS (NC),
        .CELL_DOTS (CD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_tick   (pix_tick),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .video_on   (video_on),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_char    (wr_char),
        .glyph_sel  (glyph_sel),
        .glyph_row  (glyph_row),
        .glyph_code (glyph_code),
        .pixel_on   (pixel_on)
    );

    function automatic logic [4:0] rom(input logic [3:0] c, input logic [2:0] r);
        logic [24:0] t;
        if (c == 4'd15 || r > 3'd4) return 5'b0;
        case (c)
            4'd0:    t = 25'b01110_10001_10001_10001_01110;
            4'd1:    t = 25'b11000_10000_10000_10000_11110;
            4'd7:    t = 25'b11111_00001_00010_00100_00100;
            4'd10:   t = 25'b00100_00100_11111_00100_00100;
            4'd14:   t = 25'b00000_11111_00000_11111_00000;
            default: t = {5{5'b10101}} ^ {21'b0, c};
        endcase
        return 5'(t >> (5 * (4 - int'(r))));
    endfunction

    assign glyph_code = rom(glyph_sel, glyph_row);

    typedef struct {
        int         x;
        int         y;
        logic       pix;
        logic [3:0] sel;
        logic [2:0] row;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] model [16];
    bit         band_ok;
    logic       last_pix;
    logic [3:0] last_sel;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold_checks(input string tag);
        chk({tag, " hold pixel_on"}, {7'b0, pixel_on}, {7'b0, last_pix});
        chk({tag, " hold glyph_sel"}, {4'b0, glyph_sel}, {4'b0, last_sel});
    endtask

    task automatic do_reset();
        rst = 1'b1; pix_tick = 1'b0; wr_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        band_ok  = 1'b0;
        last_pix = 1'b0;
        last_sel = 4'd15;
        for (int i = 0; i < 16; i++) model[i] = 4'd15;
        chk("reset glyph_sel", {4'b0, glyph_sel}, 8'd15);
        chk("reset glyph_row", {5'b0, glyph_row}, 8'd0);
        chk("reset pixel_on", {7'b0, pixel_on}, 8'd0);
    endtask

    task automatic wr(input int a, input int c);
        pix_tick = 1'b0; wr_en = 1'b1; wr_addr = 4'(a); wr_char = 4'(c);
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (a < NC) model[a] = 4'(c);
        hold_checks("write");
    endtask

    task automatic pix(input int x, input int y, input logic von, input bit we,
                       input int wa, input int wc, input bit stall);
        exp_t       e;
        bit         inb, hact;
        int         rel, ch, dc, dr;
        logic [4:0] g;
        if (stall) begin
            pix_tick = 1'b0; wr_en = 1'b0;
            @(posedge clk); #1;
            hold_checks("stall");
        end
        if (y == OY && x == 0) band_ok = 1'b1;
        inb  = band_ok && y >= OY && y < OY + 5 * SC;
        hact = inb && x >= OX && x < OX + NC * CD * SC;
        rel  = x - OX;
        ch   = hact ? rel / (CD * SC) : 0;
        dc   = hact ? (rel % (CD * SC)) / SC : 0;
        dr   = inb ? (y - OY) / SC : 0;
        g    = rom(model[ch], 3'(dr));
        e.x   = x;
        e.y   = y;
        e.sel = hact ? model[ch] : 4'd15;
        e.row = 3'(dr);
        e.pix = hact && von && dc < 5 && g[4 - dc];
        sb.push_back(e);
        pixel_x = 10'(x); pixel_y = 10'(y); video_on = von;
        wr_en = we; wr_addr = 4'(wa); wr_char = 4'(wc); pix_tick = 1'b1;
        @(posedge clk);
        if (we && wa < NC) model[wa] = 4'(wc);
        #1;
        wr_en = 1'b0;
        chk($sformatf("glyph_sel x%0d y%0d", x, y), {4'b0, glyph_sel}, {4'b0, sb[$].sel});
        chk($sformatf("glyph_row x%0d y%0d", x, y), {5'b0, glyph_row}, {5'b0, sb[$].row});
        last_sel = sb[$].sel;
        if (sb.size() == 2) begin
            e = sb.pop_front();
            chk($sformatf("pixel_on x%0d y%0d", e.x, e.y), {7'b0, pixel_on}, {7'b0, e.pix});
            last_pix = e.pix;
        end
    endtask

    // mode 1: mid-scan write, ignored address, video_on gap, stalls; mode 2: reset mid-band
    task automatic run_frame(input int y0, input int y1, input int mode);
        bit   we, stall;
        int   wa, wc;
        logic von;
        for (int y = y0; y <= y1; y++) begin
            for (int x = 0; x < LINE_W; x++) begin
                if (mode == 2 && y == OY + 10 && x == 100) do_reset();
                we = 1'b0; wa = 0; wc = 0;
                if (mode == 1 && y == 217 && x == 230) begin we = 1'b1; wa = 3;  wc = 14; end
                if (mode == 1 && y == 218 && x == 10)  begin we = 1'b1; wa = 12; wc = 8;  end
                von   = !(mode == 1 && y >= 216 && y <= 219 && x >= 150 && x < 300);
                stall = (mode == 1 && y == 216 && (x % 37) == 0);
                pix(x, y, von, we, wa, wc, stall);
            end
        end
    endtask

    initial begin
        rst = 1'b1; pix_tick = 1'b0; video_on = 1'b0; wr_en = 1'b0;
        wr_addr = '0; wr_char = '0; pixel_x = '0; pixel_y = '0;
        @(posedge clk);
        do_reset();

        run_frame(198, 241, 0);

        wr(0, 10);
        wr(1, 1);
        wr(3, 7);
        wr(7, 0);
        run_frame(198, 241, 1);

        run_frame(198, 241, 2);

        wr(0, 10);
        run_frame(198, 225, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
